td4_decoder: RTL

Registered instruction decoder and execution sequencer for the TD4 CPU. It sits between the program ROM, which is addressed by the PC, and the A/B/PC/output registers. It latches each 8-bit instruction and the negative-logic carry flag. It then drives one execute cycle of active-low load strobes, a source select, the immediate and a register clock enable. It also provides run/halt/single-step control so the core can be stepped from a front panel.

---
 rtl/td4_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/td4_decoder.sv
// ============================================================================
// Module   : td4_decoder
// Purpose  : TD4 instruction register, opcode decoder and HALT/FETCH/EXEC
//            sequencer with run/step control. Optional macro
//            TD4_DEC_HALT_ON_ILLEGAL_EN halts the core after an undefined opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module td4_decoder (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] Inst,
  input  logic       CFlagN,
  input  logic       Run,
  input  logic       Step,
  output logic       En,
  output logic       LoadA_n,
  output logic       LoadB_n,
  output logic       LoadOut_n,
  output logic       LoadPC_n,
  output logic [1:0] Sel,
  output logic [3:0] Im,
  output logic       Halted,
  output logic       Retired,
  output logic       Illegal
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [1:0] c_SEL_A    = 2'b00;
  localparam logic [1:0] c_SEL_B    = 2'b01;
  localparam logic [1:0] c_SEL_IN   = 2'b10;
  localparam logic [1:0] c_SEL_ZERO = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_ir;
  logic       r_cf;
  logic       r_step;
  logic       w_step_nxt;
  logic       w_illegal_op;
  logic       w_halt_on_illegal;

`ifdef TD4_DEC_HALT_ON_ILLEGAL_EN
  assign w_halt_on_illegal = w_illegal_op;
`else
  assign w_halt_on_illegal = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= S_HALT;
      r_ir    <= 8'h00;
      r_cf    <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      if (r_state == S_FETCH) begin
        r_ir <= Inst;
        r_cf <= CFlagN;
      end
    end
  end

  // Run has priority over Step, so a step request never sticks while free-running.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_HALT: begin
        if (Run) begin
          w_state_nxt = S_FETCH;
        end else if (Step) begin
          w_state_nxt = S_FETCH;
          w_step_nxt  = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_step_nxt = 1'b0;
        if (r_step || !Run || w_halt_on_illegal) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_HALT;
        w_step_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_illegal_op = 1'b0;
    case (r_ir[7:4])
      4'b1000, 4'b1010, 4'b1100, 4'b1101: w_illegal_op = 1'b1;
      default:                            w_illegal_op = 1'b0;
    endcase
  end

  always_comb begin
    En        = 1'b0;
    LoadA_n   = 1'b1;
    LoadB_n   = 1'b1;
    LoadOut_n = 1'b1;
    LoadPC_n  = 1'b1;
    Sel       = c_SEL_ZERO;
    Im        = r_ir[3:0];
    Retired   = 1'b0;
    Illegal   = 1'b0;
    Halted    = (r_state == S_HALT);
    if (r_state == S_EXEC) begin
      En      = 1'b1;
      Retired = 1'b1;
      Illegal = w_illegal_op;
      case (r_ir[7:4])
        4'b0000: begin Sel = c_SEL_A;    LoadA_n = 1'b0; end
        4'b0101: begin Sel = c_SEL_B;    LoadB_n = 1'b0; end
        4'b0011: begin Sel = c_SEL_ZERO; LoadA_n = 1'b0; end
        4'b0111: begin Sel = c_SEL_ZERO; LoadB_n = 1'b0; end
        4'b0001: begin Sel = c_SEL_B;    LoadA_n = 1'b0;   Im = 4'h0; end
        4'b0100: begin Sel = c_SEL_A;    LoadB_n = 1'b0;   Im = 4'h0; end
        4'b0010: begin Sel = c_SEL_IN;   LoadA_n = 1'b0;   Im = 4'h0; end
        4'b0110: begin Sel = c_SEL_IN;   LoadB_n = 1'b0;   Im = 4'h0; end
        4'b1001: begin Sel = c_SEL_B;    LoadOut_n = 1'b0; Im = 4'h0; end
        4'b1011: begin Sel = c_SEL_ZERO; LoadOut_n = 1'b0; end
        4'b1111: LoadPC_n = 1'b0;
        // CF holds the negative-logic flag, so 1 means no carry: take the jump.
        4'b1110: LoadPC_n = ~r_cf;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
